// File: rtl/pe_pkg.sv
// Shared definitions for the PE convolution sequencer: FSM states and default sizes.
package pe_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_F,
    ST_LOAD_I,
    ST_WAIT_PSUM,
    ST_MAC,
    ST_OUT,
    ST_DONE
  } state_t;

  localparam int KERNEL_DEF      = 3;
  localparam int IFMAP_DEPTH_DEF = 16;

endpackage

// File: rtl/pe_spad.sv
// Scratchpad: synchronous write port, combinational read port, contents never reset.
module pe_spad #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16,
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/pe_conv_seq.sv
// Loads a filter row and an ifmap row, then sequences K MAC ops per output of a 1-D convolution.
module pe_conv_seq
  import pe_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int PSUM_W      = 2 * DATA_W,
  parameter int KERNEL      = KERNEL_DEF,
  parameter int IFMAP_DEPTH = IFMAP_DEPTH_DEF,
  parameter int LEN_W       = $clog2(IFMAP_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic              cfg_reuse_filt,
  output logic              busy,
  output logic              done,
  input  logic [DATA_W-1:0] filt_data,
  input  logic              filt_valid,
  output logic              filt_ready,
  input  logic [DATA_W-1:0] ifmap_data,
  input  logic              ifmap_valid,
  output logic              ifmap_ready,
  input  logic [DATA_W-1:0] psum_in_data,
  input  logic              psum_in_valid,
  output logic              psum_in_ready,
  output logic [PSUM_W-1:0] psum_out_data,
  output logic              psum_out_valid,
  input  logic              psum_out_ready,
  output logic [DATA_W-1:0] mac_a,
  output logic [DATA_W-1:0] mac_w,
  output logic [DATA_W-1:0] mac_sum,
  output logic              mac_en,
  input  logic [PSUM_W-1:0] mac_out
);

  localparam int KW = (KERNEL > 1) ? $clog2(KERNEL) : 1;
  localparam int IW = (IFMAP_DEPTH > 1) ? $clog2(IFMAP_DEPTH) : 1;

  state_t             state_q, state_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [KW-1:0]      k_q, k_d;
  logic [LEN_W-1:0]   i_q, i_d;
  logic [LEN_W-1:0]   j_q, j_d;
  logic [DATA_W-1:0]  psum_q, psum_d;
  logic               filt_loaded_q, filt_loaded_d;
  logic [DATA_W-1:0]  filt_rd, ifmap_rd;

  always_comb begin
    state_d       = state_q;
    len_d         = len_q;
    k_d           = k_q;
    i_d           = i_q;
    j_d           = j_q;
    psum_d        = psum_q;
    filt_loaded_d = filt_loaded_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          len_d = cfg_len;
          k_d   = '0;
          i_d   = '0;
          if (cfg_len < LEN_W'(KERNEL))              state_d = ST_DONE;
          else if (cfg_reuse_filt && filt_loaded_q) state_d = ST_LOAD_I;
          else                                      state_d = ST_LOAD_F;
        end
      end
      ST_LOAD_F: begin
        if (filt_valid) begin
          k_d = k_q + 1'b1;
          if (k_q == KW'(KERNEL - 1)) begin
            k_d           = '0;
            filt_loaded_d = 1'b1;
            state_d       = ST_LOAD_I;
          end
        end
      end
      ST_LOAD_I: begin
        if (ifmap_valid) begin
          i_d = i_q + 1'b1;
          if (i_q == len_q - 1'b1) begin
            j_d     = '0;
            state_d = ST_WAIT_PSUM;
          end
        end
      end
      ST_WAIT_PSUM: begin
        if (psum_in_valid) begin
          psum_d  = psum_in_data;
          k_d     = '0;
          state_d = ST_MAC;
        end
      end
      ST_MAC: begin
        k_d = k_q + 1'b1;
        if (k_q == KW'(KERNEL - 1)) begin
          k_d     = '0;
          state_d = ST_OUT;
        end
      end
      ST_OUT: begin
        if (psum_out_ready) begin
          j_d = j_q + 1'b1;
          // j_d counts finished outputs; a row yields len-K+1 of them
          if (j_d == len_q - LEN_W'(KERNEL - 1)) state_d = ST_DONE;
          else                                   state_d = ST_WAIT_PSUM;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      len_q         <= '0;
      k_q           <= '0;
      i_q           <= '0;
      j_q           <= '0;
      psum_q        <= '0;
      filt_loaded_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      len_q         <= len_d;
      k_q           <= k_d;
      i_q           <= i_d;
      j_q           <= j_d;
      psum_q        <= psum_d;
      filt_loaded_q <= filt_loaded_d;
    end
  end

  pe_spad #(.WIDTH(DATA_W), .DEPTH(KERNEL)) u_filt_spad (
    .clk     (clk),
    .wr_en   (filt_ready && filt_valid),
    .wr_addr (k_q),
    .wr_data (filt_data),
    .rd_addr (k_q),
    .rd_data (filt_rd)
  );

  pe_spad #(.WIDTH(DATA_W), .DEPTH(IFMAP_DEPTH)) u_ifmap_spad (
    .clk     (clk),
    .wr_en   (ifmap_ready && ifmap_valid),
    .wr_addr (IW'(i_q)),
    .wr_data (ifmap_data),
    .rd_addr (IW'(j_q + LEN_W'(k_q))),
    .rd_data (ifmap_rd)
  );

  // Moore outputs; data ports are forced to zero outside the state that owns them
  assign busy           = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign done           = (state_q == ST_DONE);
  assign filt_ready     = (state_q == ST_LOAD_F);
  assign ifmap_ready    = (state_q == ST_LOAD_I);
  assign psum_in_ready  = (state_q == ST_WAIT_PSUM);
  assign psum_out_valid = (state_q == ST_OUT);
  assign mac_en         = (state_q == ST_MAC);
  assign mac_a          = mac_en ? ifmap_rd : '0;
  assign mac_w          = mac_en ? filt_rd : '0;
  assign mac_sum        = !mac_en ? '0 : ((k_q == '0) ? psum_q : mac_out[DATA_W-1:0]);
  assign psum_out_data  = psum_out_valid ? mac_out : '0;

endmodule

// File: tb/tb_pe_conv_seq.sv
// Directed plus randomized bench for pe_conv_seq with a behavioural MAC and a row-level reference model.
module tb_pe_conv_seq;

  localparam int DW = 16;
  localparam int PW = 32;
  localparam int K  = 3;
  localparam int D  = 16;
  localparam int LW = 5;
  localparam longint MASK_P = 64'hFFFF_FFFF;
  localparam longint MASK_D = 64'hFFFF;

  logic          clk = 1'b0;
  logic          reset, start, cfg_reuse_filt;
  logic [LW-1:0] cfg_len;
  logic          busy, done;
  logic [DW-1:0] filt_data, ifmap_data, psum_in_data;
  logic          filt_valid, filt_ready, ifmap_valid, ifmap_ready;
  logic          psum_in_valid, psum_in_ready;
  logic [PW-1:0] psum_out_data;
  logic          psum_out_valid, psum_out_ready;
  logic [DW-1:0] mac_a, mac_w, mac_sum;
  logic          mac_en;
  logic [PW-1:0] mac_out;

  int tests = 0;
  int fails = 0;

  logic [DW-1:0] filt_v [K];
  logic [DW-1:0] ifm_v  [D];
  logic [DW-1:0] ps_v   [D];
  longint        exp_q  [$];
  longint        obs_q  [$];

  always #5 clk = ~clk;

  pe_conv_seq #(.DATA_W(DW), .PSUM_W(PW), .KERNEL(K), .IFMAP_DEPTH(D), .LEN_W(LW)) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .cfg_len        (cfg_len),
    .cfg_reuse_filt (cfg_reuse_filt),
    .busy           (busy),
    .done           (done),
    .filt_data      (filt_data),
    .filt_valid     (filt_valid),
    .filt_ready     (filt_ready),
    .ifmap_data     (ifmap_data),
    .ifmap_valid    (ifmap_valid),
    .ifmap_ready    (ifmap_ready),
    .psum_in_data   (psum_in_data),
    .psum_in_valid  (psum_in_valid),
    .psum_in_ready  (psum_in_ready),
    .psum_out_data  (psum_out_data),
    .psum_out_valid (psum_out_valid),
    .psum_out_ready (psum_out_ready),
    .mac_a          (mac_a),
    .mac_w          (mac_w),
    .mac_sum        (mac_sum),
    .mac_en         (mac_en),
    .mac_out        (mac_out)
  );

  // Behavioural MAC: registered multiply-accumulate, holds while disabled
  always @(posedge clk) begin
    if (reset)       mac_out <= '0;
    else if (mac_en) mac_out <= mac_a * mac_w + mac_sum;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Sum fed into tap k of output j: the psum for k=0, else the truncated running result
  function automatic longint tap_sum(int j, int k);
    longint s = longint'(ps_v[j]);
    for (int t = 0; t < k; t++) s = ((longint'(ifm_v[j+t]) * longint'(filt_v[t]) + s) & MASK_P) & MASK_D;
    return s;
  endfunction

  function automatic void build_expected(int len);
    exp_q.delete();
    for (int j = 0; j + K <= len; j++)
      exp_q.push_back((longint'(ifm_v[j+K-1]) * longint'(filt_v[K-1]) + tap_sum(j, K-1)) & MASK_P);
  endfunction

  task automatic check_idle(input string tag);
    check({tag, ".ctrl"}, {busy, done, filt_ready, ifmap_ready, psum_in_ready, psum_out_valid, mac_en}, '0);
    check({tag, ".ops"}, {mac_a, mac_w, mac_sum}, '0);
    check({tag, ".pout"}, psum_out_data, '0);
  endtask

  task automatic run_row(input string name, input int len, input bit reuse, input bit expect_load,
                         input int bp_first, input bit gaps, input int abort_tap);
    int fi = 0, ii = 0, pi = 0, oi = 0;
    int f_seen = 0, i_seen = 0, p_seen = 0, run = 0;
    int hs_cyc = -100, last_out_cyc = -100, bp_left = bp_first;
    int nout;
    bit got_done = 0, holding = 0, expect_pin = 0, hf, hi, hp;
    logic [PW-1:0] held = '0;
    nout = (len >= K) ? len - K + 1 : 0;
    build_expected(len);
    obs_q.delete();
    start = 1'b1; cfg_len = LW'(len); cfg_reuse_filt = reuse;
    @(posedge clk); #1;
    start = 1'b0;
    for (int cyc = 1; cyc <= 400 && !got_done; cyc++) begin
      if (done) begin
        got_done = 1;
        check({name, ".outputs"}, oi, nout);
        check({name, ".done_lat"}, cyc, (nout == 0) ? 1 : last_out_cyc + 1);
        check({name, ".filt_load"}, f_seen > 0, expect_load);
        check({name, ".ifmap_load"}, i_seen > 0, nout > 0);
        check({name, ".psum_req"}, p_seen > 0, nout > 0);
      end else begin
        if (filt_ready) f_seen++;
        if (ifmap_ready) i_seen++;
        if (psum_in_ready) p_seen++;
        if (expect_pin) begin
          check({name, ".pin_reassert"}, psum_in_ready, 1'b1);
          expect_pin = 0;
        end
        if (mac_en) begin
          run++;
          if (run == 1) check({name, ".mac_lat"}, cyc, hs_cyc + 1);
          check({name, ".mac_a"}, mac_a, ifm_v[oi + run - 1]);
          check({name, ".mac_w"}, mac_w, filt_v[run - 1]);
          check({name, ".mac_sum"}, mac_sum, tap_sum(oi, run - 1));
          if (abort_tap >= 0 && run == abort_tap + 1) begin
            reset = 1'b1;
            @(posedge clk); #1;
            check_idle({name, ".abort"});
            reset = 1'b0;
            filt_valid = 1'b0; ifmap_valid = 1'b0; psum_in_valid = 1'b0; psum_out_ready = 1'b0;
            return;
          end
        end else if (run > 0) begin
          check({name, ".mac_run"}, run, K);
          run = 0;
        end
        psum_out_ready = 1'b0;
        if (psum_out_valid) begin
          if (holding) check({name, ".hold_data"}, psum_out_data, held);
          else         check({name, ".out_lat"}, cyc, hs_cyc + K + 1);
          if (bp_left > 0) begin
            bp_left--;
          end else begin
            psum_out_ready = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
          end
          if (!psum_out_ready) begin
            check({name, ".bp_mac_en"}, mac_en, 1'b0);
            check({name, ".bp_pin_rdy"}, psum_in_ready, 1'b0);
            holding = 1;
            held    = psum_out_data;
          end else begin
            check({name, ".psum_out"}, psum_out_data, (oi < exp_q.size()) ? exp_q[oi] : 64'hDEAD);
            obs_q.push_back(longint'(psum_out_data));
            oi++;
            holding      = 0;
            last_out_cyc = cyc;
            expect_pin   = (oi < nout);
          end
        end
        filt_valid    = (fi < K) && (!gaps || $urandom_range(0, 1) == 1);
        filt_data     = (fi < K) ? filt_v[fi] : '0;
        ifmap_valid   = (ii < len) && (!gaps || $urandom_range(0, 1) == 1);
        ifmap_data    = (ii < len) ? ifm_v[ii] : '0;
        psum_in_valid = (pi < nout) && (!gaps || $urandom_range(0, 1) == 1);
        psum_in_data  = (pi < nout) ? ps_v[pi] : '0;
        hf = filt_ready && filt_valid;
        hi = ifmap_ready && ifmap_valid;
        hp = psum_in_ready && psum_in_valid;
        if (hp) hs_cyc = cyc;
        @(posedge clk); #1;
        if (hf) fi++;
        if (hi) ii++;
        if (hp) pi++;
      end
    end
    filt_valid = 1'b0; ifmap_valid = 1'b0; psum_in_valid = 1'b0; psum_out_ready = 1'b0;
    check({name, ".finished"}, got_done, 1'b1);
    @(posedge clk); #1;
    check({name, ".done_pulse"}, {done, busy}, 2'b00);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; cfg_len = '0; cfg_reuse_filt = 1'b0;
    filt_data = '0; filt_valid = 1'b0; ifmap_data = '0; ifmap_valid = 1'b0;
    psum_in_data = '0; psum_in_valid = 1'b0; psum_out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_idle("reset");
    reset = 1'b0;
    @(posedge clk); #1;

    // Basic row with the first output held off for 5 cycles
    filt_v = '{16'd1, 16'd2, 16'd3};
    for (int i = 0; i < 5; i++) ifm_v[i] = DW'(i + 1);
    ps_v[0] = 16'd0; ps_v[1] = 16'd10; ps_v[2] = 16'd100;
    run_row("basic", 5, 1'b0, 1'b1, 5, 1'b0, -1);
    check("basic.out0", obs_q.size() > 0 ? obs_q[0] : -1, 14);
    check("basic.out1", obs_q.size() > 1 ? obs_q[1] : -1, 30);
    check("basic.out2", obs_q.size() > 2 ? obs_q[2] : -1, 126);

    for (int i = 0; i < 3; i++) ifm_v[i] = 16'd2;
    ps_v[0] = 16'd0;
    run_row("reuse", 3, 1'b1, 1'b0, 0, 1'b0, -1);
    check("reuse.out0", obs_q.size() > 0 ? obs_q[0] : -1, 12);

    run_row("short", 2, 1'b0, 1'b0, 0, 1'b0, -1);

    for (int i = 0; i < 4; i++) ifm_v[i] = DW'($urandom);
    for (int i = 0; i < 2; i++) ps_v[i] = DW'($urandom);
    run_row("abort", 4, 1'b0, 1'b1, 0, 1'b0, 1);
    run_row("post_abort", 4, 1'b1, 1'b1, 0, 1'b0, -1);

    filt_v = '{16'h0100, 16'h0100, 16'h0100};
    for (int i = 0; i < 3; i++) ifm_v[i] = 16'h0100;
    ps_v[0] = 16'd0;
    run_row("trunc", 3, 1'b0, 1'b1, 0, 1'b0, -1);
    check("trunc.out0", obs_q.size() > 0 ? obs_q[0] : -1, 64'h0001_0000);

    for (int r = 0; r < 6; r++) begin
      int len;
      bit reuse;
      len   = $urandom_range(K, D);
      reuse = 1'($urandom_range(0, 1));
      if (!reuse) for (int k = 0; k < K; k++) filt_v[k] = DW'($urandom);
      for (int i = 0; i < D; i++) begin
        ifm_v[i] = DW'($urandom);
        ps_v[i]  = DW'($urandom);
      end
      run_row("rand", len, reuse, !reuse, $urandom_range(0, 3), 1'b1, -1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
